// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: bundle between the instruction register / datapath and
// the multi-cycle control unit. The control unit drives through the master
// modport; the datapath side (or a testbench) uses the slave modport.
// There is no valid/ready pair here. Every strobe (PCWrite, IRWrite, MemW,
// RegW, InstrDone) is a single-cycle command that the datapath acts on at the
// next rising clock edge. Instr must stay stable from the end of FETCH until
// InstrDone. State exposes the FSM encoding for debug and checkers:
// 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXECR, 7 EXECI,
// 8 ALUWB, 9 BRANCH.
interface mc_control_unit_if #(
  parameter int ALU_CTRL_W = 2
);
  logic [31:0]           Instr;
  logic [3:0]            ALUFlags;
  logic                  PCWrite;
  logic                  AdrSrc;
  logic                  IRWrite;
  logic                  MemW;
  logic                  RegW;
  logic [1:0]            ResultSrc;
  logic                  ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [1:0]            ImmSrc;
  logic [1:0]            RegSrc;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic [3:0]            Flags;
  logic                  InstrDone;
  logic [3:0]            State;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, IRWrite, MemW, RegW, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegSrc, ALUControl, Flags, InstrDone, State
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, IRWrite, MemW, RegW, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegSrc, ALUControl, Flags, InstrDone, State
  );
endinterface

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle control unit for the ARM-subset CPU.
// Main decoder FSM, ALU decoder, condition check and NZCV flag register.
// Memory states (FETCH, MEMRD, MEMWR) are stretched by MEM_WAIT cycles.
// Optional feature macro: MC_CTRL_EXT_ALU_EN adds EOR/MOV and the
// no-writeback compares TST/CMP/CMN, and widens ALUControl to 3 bits.
module mc_control_unit #(
  parameter logic [1:0] MEM_WAIT = 2'd0,
`ifdef MC_CTRL_EXT_ALU_EN
  parameter int ALU_CTRL_W = 3
`else
  parameter int ALU_CTRL_W = 2
`endif
) (
  input logic                CLK,
  input logic                RESETn,
  mc_control_unit_if.master  bus
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXECR  = 4'd6;
  localparam logic [3:0] EXECI  = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
`ifdef MC_CTRL_EXT_ALU_EN
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;
`endif

  logic [3:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;

  // Instruction fields
  logic [3:0] cond;
  logic [1:0] op;
  logic       i_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic       u_bit;
  logic       l_mem;
  logic       l_br;
  logic [3:0] rd;

  assign cond  = bus.Instr[31:28];
  assign op    = bus.Instr[27:26];
  assign i_bit = bus.Instr[25];
  assign cmd   = bus.Instr[24:21];
  assign s_bit = bus.Instr[20];
  assign u_bit = bus.Instr[23];
  assign l_mem = bus.Instr[20];
  assign l_br  = bus.Instr[24];
  assign rd    = bus.Instr[15:12];

  // Data-processing decode: ALU op, legality, compare (no writeback), arithmetic (loads C/V)
  logic [2:0] dp_alu;
  logic       dp_valid;
  logic       dp_cmp;
  logic       dp_arith;

  always_comb begin
    dp_alu   = ALU_ADD;
    dp_valid = 1'b0;
    dp_cmp   = 1'b0;
    dp_arith = 1'b0;
    case (cmd)
      4'b0100: begin dp_alu = ALU_ADD; dp_valid = 1'b1; dp_arith = 1'b1; end
      4'b0010: begin dp_alu = ALU_SUB; dp_valid = 1'b1; dp_arith = 1'b1; end
      4'b0000: begin dp_alu = ALU_AND; dp_valid = 1'b1; end
      4'b1100: begin dp_alu = ALU_ORR; dp_valid = 1'b1; end
`ifdef MC_CTRL_EXT_ALU_EN
      4'b0001: begin dp_alu = ALU_EOR; dp_valid = 1'b1; end
      4'b1101: begin dp_alu = ALU_MOV; dp_valid = 1'b1; end
      4'b1000: begin dp_alu = ALU_AND; dp_valid = 1'b1; dp_cmp = 1'b1; end
      4'b1010: begin dp_alu = ALU_SUB; dp_valid = 1'b1; dp_cmp = 1'b1; dp_arith = 1'b1; end
      4'b1011: begin dp_alu = ALU_ADD; dp_valid = 1'b1; dp_cmp = 1'b1; dp_arith = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Condition check of Instr[31:28] against the registered NZCV flags
  logic fn, fz, fc, fv;
  logic cond_ok;
  assign {fn, fz, fc, fv} = flags_q;

  always_comb begin
    case (cond)
      4'h0:    cond_ok = fz;
      4'h1:    cond_ok = ~fz;
      4'h2:    cond_ok = fc;
      4'h3:    cond_ok = ~fc;
      4'h4:    cond_ok = fn;
      4'h5:    cond_ok = ~fn;
      4'h6:    cond_ok = fv;
      4'h7:    cond_ok = ~fv;
      4'h8:    cond_ok = fc & ~fz;
      4'h9:    cond_ok = ~fc | fz;
      4'ha:    cond_ok = (fn == fv);
      4'hb:    cond_ok = (fn != fv);
      4'hc:    cond_ok = ~fz & (fn == fv);
      4'hd:    cond_ok = fz | (fn != fv);
      4'he:    cond_ok = 1'b1;
      default: cond_ok = 1'b0;  // 1111 is reserved: never execute
    endcase
  end

  // Memory states hold until the wait counter reaches MEM_WAIT
  logic wait_done;
  assign wait_done = (cnt_q == MEM_WAIT);

  // DECODE ends the instruction on a failed condition or an undefined encoding
  logic decode_nop;
  assign decode_nop = ~cond_ok | (op == 2'b11) | ((op == 2'b00) & ~dp_valid);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (wait_done) state_d = DECODE;
      DECODE: begin
        if (decode_nop)        state_d = FETCH;
        else if (op == 2'b01)  state_d = MEMADR;
        else if (op == 2'b10)  state_d = BRANCH;
        else                   state_d = i_bit ? EXECI : EXECR;
      end
      MEMADR: state_d = l_mem ? MEMRD : MEMWR;
      MEMRD:  if (wait_done) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (wait_done) state_d = FETCH;
      EXECR,
      EXECI:  state_d = dp_cmp ? FETCH : ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Wait counter clears on every state change and saturates at MEM_WAIT
  always_comb begin
    if (state_d != state_q) cnt_d = 2'd0;
    else if (wait_done)     cnt_d = cnt_q;
    else                    cnt_d = cnt_q + 2'd1;
  end

  // CondEx latches the condition result in DECODE; it qualifies later writes
  assign cond_ex_d = (state_q == DECODE) ? cond_ok : cond_ex_q;

  // Flags load when leaving EXEC*: NZ always, CV only for arithmetic ops
  logic flags_we;
  assign flags_we = ((state_q == EXECR) | (state_q == EXECI)) & cond_ex_q & (s_bit | dp_cmp);

  always_comb begin
    flags_d = flags_q;
    if (flags_we) begin
      flags_d[3:2] = bus.ALUFlags[3:2];
      if (dp_arith) flags_d[1:0] = bus.ALUFlags[1:0];
    end
  end

  // State, counter, flags and CondEx registers
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= FETCH;
      cnt_q     <= 2'd0;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  // Moore control outputs from the current state
  logic       pc_write, ir_write, mem_w, reg_w, instr_done;
  logic       adr_src, alu_src_a;
  logic [1:0] result_src, alu_src_b;
  logic [2:0] alu_ctrl;

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    instr_done = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    result_src = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    case (state_q)
      FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = wait_done;
        pc_write   = wait_done;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        instr_done = decode_nop;
      end
      MEMADR: begin
        alu_src_b = 2'b01;
        alu_ctrl  = u_bit ? ALU_ADD : ALU_SUB;
      end
      MEMRD: adr_src = 1'b1;
      MEMWR: begin
        adr_src    = 1'b1;
        mem_w      = wait_done & cond_ex_q;
        instr_done = wait_done;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w      = cond_ex_q;
        instr_done = 1'b1;
      end
      EXECR, EXECI: begin
        alu_src_b  = (state_q == EXECI) ? 2'b01 : 2'b00;
        alu_ctrl   = dp_alu;
        instr_done = dp_cmp;
      end
      ALUWB: begin
        result_src = 2'b00;
        reg_w      = cond_ex_q;
        pc_write   = cond_ex_q & (rd == 4'd15);
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = cond_ex_q;
        reg_w      = cond_ex_q & l_br;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are forced low combinationally while reset is asserted
  assign bus.PCWrite    = pc_write   & RESETn;
  assign bus.IRWrite    = ir_write   & RESETn;
  assign bus.MemW       = mem_w      & RESETn;
  assign bus.RegW       = reg_w      & RESETn;
  assign bus.InstrDone  = instr_done & RESETn;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = alu_ctrl[ALU_CTRL_W-1:0];
  assign bus.Flags      = flags_q;
  assign bus.State      = state_q;

  // ImmSrc follows Op; RegSrc[0] reads PC for branches, RegSrc[1] reads Rd for
  // stores and selects R14 as the link destination for BL
  assign bus.ImmSrc = (op == 2'b11) ? 2'b00 : op;
  assign bus.RegSrc = {(op == 2'b01) | ((op == 2'b10) & l_br), (op == 2'b10)};

  logic unused_bits;
  assign unused_bits = ^{bus.Instr[19:16], bus.Instr[11:0], alu_ctrl};

endmodule
